// File: rtl/cu_multicycle_pkg.sv
// ----------------------------------------------------------------------------
// cu_multicycle_pkg
// Shared definitions for the multi-cycle control unit: opcode and FSM state
// enumerations plus helpers that locate each instruction field.
// Instruction layout (MSB..LSB): {op[3:0], imm_sel, rd[RA], ra[RA], b_fld[WIDTH]}
// ----------------------------------------------------------------------------
package cu_multicycle_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_NOT = 4'd7,
        OP_XOR = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10,
        OP_LDI = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    function automatic int unsigned instr_w(int unsigned width, int unsigned ra);
        return 5 + 2 * ra + width;
    endfunction

    function automatic int unsigned ra_lsb(int unsigned width);
        return width;
    endfunction

    function automatic int unsigned rd_lsb(int unsigned width, int unsigned ra);
        return width + ra;
    endfunction

    function automatic int unsigned imm_pos(int unsigned width, int unsigned ra);
        return width + 2 * ra;
    endfunction

    function automatic int unsigned op_lsb(int unsigned width, int unsigned ra);
        return width + 2 * ra + 1;
    endfunction

endpackage

// File: rtl/cu_multicycle_if.sv
// ----------------------------------------------------------------------------
// cu_multicycle_if
// Instruction/result handshake bundle plus the debug register-read port.
//   instr_valid/instr_ready/instruction  : instruction source -> unit
//   result_valid/result_ready/result     : unit -> result sink
//   flag_zero/flag_carry/flag_illegal    : flags accompanying result
//   dbg_addr/dbg_data                    : combinational register peek
// master = source/sink side, slave = control unit side.
// ----------------------------------------------------------------------------
interface cu_multicycle_if
    import cu_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4
);
    localparam int unsigned RA      = $clog2(NREG);
    localparam int unsigned INSTR_W = instr_w(WIDTH, RA);

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic               result_valid;
    logic               result_ready;
    logic [WIDTH-1:0]   result;
    logic               flag_zero;
    logic               flag_carry;
    logic               flag_illegal;
    logic [RA-1:0]      dbg_addr;
    logic [WIDTH-1:0]   dbg_data;

    modport master (
        output instr_valid, instruction, result_ready, dbg_addr,
        input  instr_ready, result_valid, result,
               flag_zero, flag_carry, flag_illegal, dbg_data
    );

    modport slave (
        input  instr_valid, instruction, result_ready, dbg_addr,
        output instr_ready, result_valid, result,
               flag_zero, flag_carry, flag_illegal, dbg_data
    );

endinterface

// File: rtl/cu_multicycle_alu.sv
// ----------------------------------------------------------------------------
// cu_multicycle_alu
// Combinational ALU for the control unit.
//   op_i      : opcode
//   a_i, b_i  : operands
//   result_o  : result modulo 2^WIDTH
//   carry_o   : carry (ADD/INC/SHL), borrow (SUB/DEC), shifted-out bit (SHR)
//   illegal_o : opcode outside the defined set (result and carry forced 0)
// ----------------------------------------------------------------------------
module cu_multicycle_alu
    import cu_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             illegal_o
);

    // Every op is evaluated one bit wider; the top bit is the carry/borrow.
    logic [WIDTH:0] wide;

    always_comb begin
        wide      = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_NOP: wide = '0;
            OP_ADD: wide = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB: wide = {1'b0, a_i} - {1'b0, b_i};
            OP_INC: wide = {1'b0, a_i} + (WIDTH+1)'(1);
            OP_DEC: wide = {1'b0, a_i} - (WIDTH+1)'(1);
            OP_AND: wide = {1'b0, a_i & b_i};
            OP_OR:  wide = {1'b0, a_i | b_i};
            OP_NOT: wide = {1'b0, ~a_i};
            OP_XOR: wide = {1'b0, a_i ^ b_i};
            OP_SHL: wide = {a_i, 1'b0};
            // Shifted-out LSB is parked in the carry position.
            OP_SHR: wide = {a_i[0], 1'b0, a_i[WIDTH-1:1]};
            OP_LDI: wide = {1'b0, b_i};
            default: illegal_o = 1'b1;
        endcase
    end

    assign result_o = wide[WIDTH-1:0];
    assign carry_o  = wide[WIDTH];

endmodule

// File: rtl/cu_multicycle.sv
// ----------------------------------------------------------------------------
// cu_multicycle
// Multi-cycle control unit: accepts one instruction in IDLE, executes it in
// EXEC (register read, ALU, write-back into reg[rd]) and presents the result
// and flags in WB until the sink accepts.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : cu_multicycle_if.slave (instruction/result handshakes, debug read)
// ----------------------------------------------------------------------------
module cu_multicycle
    import cu_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4
) (
    input  logic           clk,
    input  logic           rst,
    cu_multicycle_if.slave bus
);

    localparam int unsigned RA      = $clog2(NREG);
    localparam int unsigned INSTR_W = instr_w(WIDTH, RA);
    localparam int unsigned RA_LSB  = ra_lsb(WIDTH);
    localparam int unsigned RD_LSB  = rd_lsb(WIDTH, RA);
    localparam int unsigned IMM_POS = imm_pos(WIDTH, RA);
    localparam int unsigned OP_LSB  = op_lsb(WIDTH, RA);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [WIDTH-1:0]   regs_q [NREG];
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, carry_q, illegal_q;

    logic [3:0]         op;
    logic               imm_sel;
    logic [RA-1:0]      rd, ra;
    logic [WIDTH-1:0]   b_fld, opa, opb;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_illegal;
    logic               wr_en;

    assign op      = instr_q[OP_LSB +: 4];
    assign imm_sel = instr_q[IMM_POS];
    assign rd      = instr_q[RD_LSB +: RA];
    assign ra      = instr_q[RA_LSB +: RA];
    assign b_fld   = instr_q[WIDTH-1:0];

    assign opa = regs_q[ra];
    assign opb = imm_sel ? b_fld : regs_q[b_fld[RA-1:0]];

    cu_multicycle_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i      (op),
        .a_i       (opa),
        .b_i       (opb),
        .result_o  (alu_res),
        .carry_o   (alu_carry),
        .illegal_o (alu_illegal)
    );

    assign wr_en = (state_q == S_EXEC) && (op != OP_NOP) && !alu_illegal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.instr_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    if (bus.result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.instr_valid) begin
                instr_q <= bus.instruction;
            end
            // Operands are combinational reads of regs_q, so rd==ra still
            // computes with the pre-write value.
            if (state_q == S_EXEC) begin
                result_q  <= alu_res;
                zero_q    <= (alu_res == '0) && !alu_illegal;
                carry_q   <= alu_carry;
                illegal_q <= alu_illegal;
            end
            if (wr_en) begin
                regs_q[rd] <= alu_res;
            end
        end
    end

    assign bus.instr_ready  = (state_q == S_IDLE);
    assign bus.result_valid = (state_q == S_WB);
    assign bus.result       = result_q;
    assign bus.flag_zero    = zero_q;
    assign bus.flag_carry   = carry_q;
    assign bus.flag_illegal = illegal_q;
    assign bus.dbg_data     = regs_q[bus.dbg_addr];

endmodule
